delta_sigma_decimator: RTL and testbench
========================================

# delta_sigma_decimator

First-order-compatible ΔΣ analog-to-digital back end. It takes the 1-bit density stream from an external comparator/modulator loop (`pulse_in`) and produces unsigned multi-bit samples. It uses a 2nd-order CIC (sinc²) decimator with a power-of-two ratio. It is the return path of the `delta_sigma` DAC: a stream whose ones-density is d yields `data_out ≈ d·2^WIDTH`, saturated.

## Interface
- `WIDTH`, 9: output sample width, bits.
- `LOG2_RATIO`, 8: decimation ratio R = 2^LOG2_RATIO. Elaboration-time check: 2·LOG2_RATIO ≥ WIDTH.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pulse_in` input 1: 1-bit ΔΣ stream; may be asynchronous to `clk`.
- `data_out` output WIDTH: latest decimated sample, unsigned; holds between updates.
- `data_valid` output 1: one-cycle strobe, high in the cycle after `data_out` updates.

## Operation
- Internal width N = 2·LOG2_RATIO + 1. All integrator and comb arithmetic is unsigned modulo 2^N. Wrap-around is intentional and must not be detected or saturated.
- Synchronizer: two flops, `s1 <= pulse_in`, `s <= s1`. Both reset to 0. Only `s` feeds the filter.
- Integrators, every cycle: `i1 <= i1 + s`, `i2 <= i2 + i1`. Both reset to 0.
- Phase counter: LOG2_RATIO bits, reset 0, +1 every cycle, wraps R-1 → 0.
- Decimation boundary: the edge at which phase == R-1.
- At a boundary, combinationally from current register values (before that edge's integrator update):
  - `c1 = i2 - i2_d`
  - `c2 = c1 - c1_d`
- Then register `i2_d <= i2`, `c1_d <= c1`. Both reset to 0.
- Scaling: `raw = c2`, range 0..2^(2·LOG2_RATIO). `scaled = raw >> (2·LOG2_RATIO - WIDTH)`. `data_out <= min(scaled, 2^WIDTH - 1)`, so full-scale ones saturates to all-ones.
- Warm-up: a 2-bit counter, reset 0, increments at each boundary and saturates at 2.
  - At boundaries where the counter (pre-increment) is < 2: combs and delays update as above, but `data_out` and `data_valid` do not change.
  - The first two outputs contain incomplete filter history and are discarded.
- Sinc² steady-state response: constant ones-density d gives raw = d·R² exactly for d = 0, 1, and for periodic patterns whose period divides R.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, and every internal register = 0.
- `reset_n` assertion takes effect immediately and asynchronously. Asserting it mid-operation discards all filter history and restarts warm-up.
- Boundary edges, counted from the first rising edge after `reset_n` release: edges R, 2R, 3R, ….
- The first `data_valid` is high in the cycle after edge 3R. After that it pulses every R cycles, exactly one cycle wide, never back-to-back.
- `data_out` changes only at boundary edges from 3R onward. It is stable during the `data_valid` cycle and until the next update.
- Input latency: the `pulse_in` level sampled at edge t enters `i1` at edge t+2.
- Filter group delay is R-1 samples. A density step is fully reflected two valid outputs after it crosses the synchronizer.
- Throughput: one sample per R clocks. There is no back-pressure, and the consumer must capture on `data_valid`.

## Test plan
Defaults apply throughout: WIDTH 9, R 256.

1. **Reset values.** Hold `reset_n` low with `pulse_in` toggling → `data_out` = 0, `data_valid` = 0. Release → `data_valid` stays 0 through edge 3R-1 and first pulses after edge 3R.
2. **Constant levels.**
   - `pulse_in` held 0 → every valid `data_out` = 0.
   - `pulse_in` held 1 → every valid `data_out` = 511 (raw 65536 saturated).
   - Run at least 2000 cycles so `i2` wraps modulo 2^17; output must stay 511.
3. **Density patterns.**
   - Alternating 1,0 → `data_out` = 256 on every valid.
   - Pattern 1,0,0,0 → 128.
   - Pattern 1,1,1,0 → 384.
4. **Density step.** 1,0 pattern, then after several outputs switch to constant 0 → outputs go 256 → one intermediate value → 0 by the second valid after the switch. Each `data_valid` is one cycle wide and R cycles apart.
5. **Reset mid-operation.** Assert `reset_n` for 3 cycles at phase ≈ R/2 while outputting 256 → `data_out` = 0 immediately. The next `data_valid` appears only after edge 3R from release, with the correct value.
6. **Comparison with `delta_sigma`.** Loop a `delta_sigma` DAC's `pulse_out` into `pulse_in` with DAC `data_in` codes 64 / 200 / 450 (all 9-bit) → `data_out` matches each code within ±1 after warm-up.

Source files
------------

// File: rtl/delta_sigma_decimator.sv
// delta_sigma_decimator: sinc^2 (2nd-order CIC) decimator for a 1-bit delta-sigma stream.
// The decimation ratio is a power of two, R = 2**LOG2_RATIO, and the output is unsigned,
// saturated, WIDTH bits wide. A ones-density d produces data_out ~= d * 2**WIDTH.
module delta_sigma_decimator #(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned LOG2_RATIO = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  // Internal modular width: the comb output spans 0..R^2 and needs one bit above 2*LOG2_RATIO.
  localparam int unsigned N     = 2 * LOG2_RATIO + 1;
  localparam int unsigned Shift = 2 * LOG2_RATIO - WIDTH;

  localparam logic [LOG2_RATIO-1:0] PhaseLast = '1;
  localparam logic [LOG2_RATIO-1:0] PhaseOne  = {{(LOG2_RATIO-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]          SatMax    = {{(N-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [1:0]            WarmDone  = 2'd2;

  // Reject parameter sets whose filter gain cannot cover the output width.
  if (2 * LOG2_RATIO < WIDTH) begin : g_param_check
    $error("delta_sigma_decimator: 2*LOG2_RATIO must be >= WIDTH");
  end

  logic                  s1_q, s_q;
  logic [N-1:0]          i1_q, i2_q;
  logic [LOG2_RATIO-1:0] phase_q;
  logic [N-1:0]          i2_dly_q, c1_dly_q;
  logic [1:0]            warm_q;
  logic [WIDTH-1:0]      data_out_q;
  logic                  data_valid_q;

  logic                  boundary;
  logic                  emit;
  logic [N-1:0]          c1, c2;
  logic [N-1:0]          scaled;
  logic [WIDTH-1:0]      sample;

  // Comb section and output scaling, evaluated from pre-edge register values.
  always_comb begin
    boundary = (phase_q == PhaseLast);
    emit     = boundary && (warm_q == WarmDone);
    // Arithmetic wraps modulo 2^N on purpose; the second difference undoes the integrator
    // wrap-around as long as N covers the true comb output range.
    c1       = i2_q - i2_dly_q;
    c2       = c1 - c1_dly_q;
    scaled   = c2 >> Shift;
    if (scaled > SatMax) begin
      sample = {WIDTH{1'b1}};
    end else begin
      sample = scaled[WIDTH-1:0];
    end
  end

  // Two-flop synchronizer; pulse_in may be asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= pulse_in;
      s_q  <= s1_q;
    end
  end

  // Integrator cascade, running at the full clock rate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1_q <= '0;
      i2_q <= '0;
    end else begin
      i1_q <= i1_q + {{(N-1){1'b0}}, s_q};
      i2_q <= i2_q + i1_q;
    end
  end

  // Decimation phase counter; wraps naturally at R.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PhaseOne;
    end
  end

  // Comb delay registers, updated once per decimated sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i2_dly_q <= '0;
      c1_dly_q <= '0;
    end else if (boundary) begin
      i2_dly_q <= i2_q;
      c1_dly_q <= c1;
    end
  end

  // Warm-up counter: the first two decimated samples carry incomplete history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= '0;
    end else if (boundary && (warm_q != WarmDone)) begin
      warm_q <= warm_q + 2'd1;
    end
  end

  // Output sample register and its one-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= emit;
      if (emit) begin
        data_out_q <= sample;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_delta_sigma_decimator.sv
// Directed bench for delta_sigma_decimator (WIDTH 9, R 256): reset, constant levels,
// density patterns, density step, mid-run reset and a first-order DAC stream model.
module tb_delta_sigma_decimator;

  localparam int unsigned Width = 9;
  localparam int unsigned Log2R = 8;
  localparam int          R     = 256;

  localparam int ModeZero = 0;
  localparam int ModeOne  = 1;
  localparam int ModePat  = 2;
  localparam int ModeDac  = 3;

  logic             clk;
  logic             reset_n;
  logic             pulse_in;
  logic [Width-1:0] data_out;
  logic             data_valid;

  int n_checks = 0;
  int n_errors = 0;

  int         mode     = ModePat;
  logic [3:0] pat_bits = 4'b0001;
  int         pat_len  = 2;
  logic [8:0] dac_code = '0;

  delta_sigma_decimator #(
    .WIDTH      (Width),
    .LOG2_RATIO (Log2R)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pulse_in   (pulse_in),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus source: changes pulse_in on falling edges only.
  initial begin
    int         idx;
    logic [8:0] acc;
    logic [9:0] sum;
    idx      = 0;
    acc      = '0;
    pulse_in = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        ModeZero: pulse_in = 1'b0;
        ModeOne:  pulse_in = 1'b1;
        ModePat: begin
          if (idx >= pat_len) idx = 0;
          pulse_in = pat_bits[idx];
          idx = (idx + 1) % pat_len;
        end
        default: begin
          // First-order delta-sigma DAC: carry out of a 9-bit phase accumulator.
          sum      = {1'b0, acc} + {1'b0, dac_code};
          pulse_in = sum[9];
          acc      = sum[8:0];
        end
      endcase
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp, input int tol);
    n_checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Wait for the next data_valid, sampling 1 time unit after each rising edge.
  // Returns the number of edges waited; a missing strobe fails the tag check.
  task automatic next_sample(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!data_valid && n < 4 * R);
    check_val({tag, "_valid"}, int'(data_valid), 1, 0);
  endtask

  task automatic skip_samples(input string tag, input int count);
    int n;
    for (int k = 0; k < count; k++) next_sample(tag, n);
  endtask

  task automatic set_pattern(input logic [3:0] bits, input int len);
    pat_bits = bits;
    pat_len  = len;
    mode     = ModePat;
  endtask

  initial begin
    int n;
    int early;

    // Reset values with the input toggling.
    reset_n = 1'b0;
    set_pattern(4'b0001, 2);
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_data_out", int'(data_out), 0, 0);
    check_val("rst_valid", int'(data_valid), 0, 0);

    // Release and count edges up to the first strobe.
    @(negedge clk);
    mode    = ModeZero;
    reset_n = 1'b1;
    early   = 0;
    for (int t = 1; t < 3 * R; t++) begin
      @(posedge clk);
      #1;
      if (data_valid) early++;
    end
    check_val("warmup_early_valid", early, 0, 0);
    @(posedge clk);
    #1;
    check_val("first_valid_at_3R", int'(data_valid), 1, 0);
    check_val("first_zero", int'(data_out), 0, 0);
    @(posedge clk);
    #1;
    check_val("valid_one_wide", int'(data_valid), 0, 0);

    // Constant zero.
    for (int k = 0; k < 2; k++) begin
      next_sample("zero", n);
      check_val("zero_out", int'(data_out), 0, 0);
    end

    // Constant one, long enough for i2 to wrap; saturated full scale.
    mode = ModeOne;
    skip_samples("one_skip", 3);
    for (int k = 0; k < 8; k++) begin
      next_sample("one", n);
      check_val("one_out", int'(data_out), 511, 0);
      check_val("one_period", n, R, 0);
    end

    // Density patterns.
    set_pattern(4'b0001, 2);
    skip_samples("p10_skip", 3);
    for (int k = 0; k < 2; k++) begin
      next_sample("p10", n);
      check_val("p10_out", int'(data_out), 256, 0);
    end
    set_pattern(4'b0001, 4);
    skip_samples("p1000_skip", 3);
    for (int k = 0; k < 2; k++) begin
      next_sample("p1000", n);
      check_val("p1000_out", int'(data_out), 128, 0);
    end
    set_pattern(4'b0111, 4);
    skip_samples("p1110_skip", 3);
    for (int k = 0; k < 2; k++) begin
      next_sample("p1110", n);
      check_val("p1110_out", int'(data_out), 384, 0);
    end

    // Density step from 1/2 to 0, switched right at a strobe.
    set_pattern(4'b0001, 2);
    skip_samples("step_skip", 3);
    next_sample("step_pre", n);
    check_val("step_pre_out", int'(data_out), 256, 0);
    mode = ModeZero;
    next_sample("step_mid", n);
    check_val("step_mid_out", int'(data_out), 128, 8);
    check_val("step_mid_period", n, R, 0);
    @(posedge clk);
    #1;
    check_val("step_mid_one_wide", int'(data_valid), 0, 0);
    next_sample("step_post", n);
    check_val("step_post_out", int'(data_out), 0, 0);
    check_val("step_post_period", n, R - 1, 0);

    // Reset mid-operation at about half a decimation period.
    set_pattern(4'b0001, 2);
    skip_samples("mrst_skip", 3);
    next_sample("mrst_pre", n);
    check_val("mrst_pre_out", int'(data_out), 256, 0);
    repeat (R / 2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("mrst_data_out", int'(data_out), 0, 0);
    check_val("mrst_valid", int'(data_valid), 0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    next_sample("mrst_post", n);
    check_val("mrst_latency", n, 3 * R, 0);
    check_val("mrst_post_out", int'(data_out), 256, 0);

    // First-order DAC stream at several codes.
    for (int c = 0; c < 3; c++) begin
      int code;
      code     = (c == 0) ? 64 : (c == 1) ? 200 : 450;
      dac_code = 9'(code);
      mode     = ModeDac;
      skip_samples("dac_skip", 3);
      for (int k = 0; k < 2; k++) begin
        next_sample("dac", n);
        check_val($sformatf("dac_%0d", code), int'(data_out), code, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
